panel_scan_ctrl: RTL and testbench
==================================

Name: panel_scan_ctrl

Overview:
Scan sequencer for the 32x16 RGB LED panel, driven at 1/8 scan with two half-panels sharing row address abc.
- Generates sclk, lat, blank and abc.
- Supplies the (col, row, plane) read address to the pixel/framebuffer path, which returns r1..b2 combinationally.
- Adds binary-code-modulation (BCM) brightness with DEPTH bit-planes per row.
- Replaces the free-running sequential counter in the panel top level.

Parameters:
- NUM_COLS, 32: columns shifted per row. Power of 2.
- NUM_ROWS, 8: scan rows driven on abc. Power of 2.
- DEPTH, 4: BCM bit-planes per colour channel.
- BASE_TICKS, 16: display cycles for plane 0. Plane p displays BASE_TICKS<<p cycles.
- GUARD_TICKS, 2: blanked cycles after latch. Used only with the optional feature.

Ports:
- clk, in, 1: system clock. Every flop is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: run enable. Sampled in IDLE and at each frame boundary.
- sclk, out, 1: panel shift clock.
- lat, out, 1: panel latch strobe.
- blank, out, 1: panel output-enable. High means LEDs off.
- abc, out, 3: panel row address (log2 NUM_ROWS).
- col, out, 5: column being shifted (log2 NUM_COLS). Goes to the pixel path.
- row, out, 3: row being shifted. Goes to the pixel path.
- plane, out, 2: BCM bit-plane being shifted (log2 DEPTH).
- frame_done, out, 1: one-cycle pulse at the end of each frame.

Behaviour:
- Reset (synchronous, active-high), applied on the next clk edge from any state, including mid-shift or mid-display:
  - state = IDLE.
  - sclk = 0, lat = 0, blank = 1, frame_done = 0.
  - abc = 0, col = 0, row = 0, plane = 0.
  - All outputs are registered, with no combinational path from en.
- IDLE:
  - blank = 1, sclk = 0.
  - If en = 1, go to SHIFT on the next cycle with col = 0.
- SHIFT: two cycles per column.
  - Phase 0: sclk = 0, col = k, data settles.
  - Phase 1: sclk = 1, the panel captures on the rising sclk.
  - After phase 1 of col NUM_COLS-1: col <= 0 and go to LATCH.
  - SHIFT lasts 2*NUM_COLS = 64 cycles. blank = 1 throughout.
- LATCH: one cycle.
  - lat = 1, blank = 1, sclk = 0.
  - abc <= row on entry, so abc equals row during the LATCH cycle.
  - Next state is GUARD when the feature is enabled, otherwise DISPLAY.
- DISPLAY:
  - blank = 0 for exactly BASE_TICKS<<plane cycles, counted by a down-counter.
  - On the last display cycle, advance the scan position:
    - If plane < DEPTH-1: plane++.
    - Else: plane = 0 and row++.
    - If row wraps from NUM_ROWS-1 to 0: assert frame_done for the next single cycle.
- Next state after DISPLAY:
  - Mid-frame: always SHIFT.
  - At a frame boundary: SHIFT if en = 1, else IDLE.
  - Deasserting en mid-frame has no effect until the frame boundary. Frames always complete.
- Cycles per (row, plane) = 2*NUM_COLS + 1 + (BASE_TICKS<<plane).
- Frame with defaults = 8 × (4×65 + 240) = 4000 cycles.
- Width rules:
  - The display counter is log2(BASE_TICKS)+DEPTH bits wide.
  - col, row and plane wrap by explicit compare, never by overflow, so non-power-of-2 DEPTH is legal.
- Reset asserted in the same cycle as en: reset wins.

Optional Feature:
- Macro: SCAN_GHOST_GUARD_EN.
- Defined: a GUARD state sits between LATCH and DISPLAY, holding blank = 1 for GUARD_TICKS cycles while abc settles, to suppress row ghosting. Frame = 4000 + 32×GUARD_TICKS cycles (4064 with defaults).
- Undefined: the GUARD state, its counter logic and the GUARD_TICKS usage are all absent. LATCH goes directly to DISPLAY.

Decomposition:
- Package scan_pkg holds:
  - the state enum: IDLE, SHIFT, LATCH, GUARD, DISPLAY;
  - the default constants NUM_COLS, NUM_ROWS and DEPTH;
  - derived widths COL_W, ROW_W and PLANE_W as localparams via $clog2.
- One sub-module, scan_timer: a loadable down-counter with a done flag. It is shared by the DISPLAY and GUARD states.

Test Plan:
- Reset held 3 cycles with en = 1, then released: outputs equal the reset values during reset. The first SHIFT has col = 0 and sclk = 0 on cycle 1 after release.
- Free run with en = 1: count 32 sclk rising edges, then lat = 1 for exactly 1 cycle with abc = row. blank is low for 16/32/64/128 cycles for planes 0..3.
- Full frame: frame_done pulses exactly once per 4000 cycles (4064 with SCAN_GHOST_GUARD_EN). row wraps 7 → 0 and plane wraps 3 → 0 in the same cycle.
- en dropped at frame cycle 1000: the frame runs to cycle 4000, frame_done pulses, then the block enters IDLE with blank = 1 held and no further sclk.
- rst pulsed for 1 cycle mid-DISPLAY (row = 5, plane = 2): next cycle all outputs equal the reset values. Scanning restarts from row 0, plane 0.
- Assertion over all runs: lat = 1 implies sclk = 0 and blank = 1. blank = 0 only in the DISPLAY state.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and default geometry for the LED panel scan controller.
package scan_pkg;

   localparam int NUM_COLS    = 32;
   localparam int NUM_ROWS    = 8;
   localparam int DEPTH       = 4;
   localparam int BASE_TICKS  = 16;
   localparam int GUARD_TICKS = 2;

   localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int PLANE_W = (DEPTH > 1)    ? $clog2(DEPTH)    : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      LATCH   = 3'd2,
      GUARD   = 3'd3,
      DISPLAY = 3'd4
   } scan_state_e;

   // BCM weighting: plane p is lit for base << p cycles.
   function automatic int unsigned plane_ticks(input int unsigned base, input int unsigned plane);
      return base << plane;
   endfunction

endpackage

// File: rtl/panel_scan_ctrl_if.sv
// Panel-side signal bundle: run enable in, scan timing and pixel address out.
interface panel_scan_ctrl_if;
   import scan_pkg::*;

   logic               en;
   logic               sclk;
   logic               lat;
   logic               blank;
   logic [ROW_W-1:0]   abc;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [PLANE_W-1:0] plane;
   logic               frame_done;

   modport master (
      input  en,
      output sclk, lat, blank, abc, col, row, plane, frame_done
   );

   modport slave (
      output en,
      input  sclk, lat, blank, abc, col, row, plane, frame_done
   );

endinterface

// File: rtl/scan_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module scan_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   // Count down to zero and hold; a load always takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/panel_scan_ctrl.sv
// 1/8-scan BCM sequencer for the 32x16 RGB panel: sclk/lat/blank/abc plus pixel read address.
// Define SCAN_GHOST_GUARD_EN to insert a blanked GUARD interval between LATCH and DISPLAY.
module panel_scan_ctrl #(
   parameter int NUM_COLS   = scan_pkg::NUM_COLS,
   parameter int NUM_ROWS   = scan_pkg::NUM_ROWS,
   parameter int DEPTH      = scan_pkg::DEPTH,
   parameter int BASE_TICKS = scan_pkg::BASE_TICKS
`ifdef SCAN_GHOST_GUARD_EN
   ,
   parameter int GUARD_TICKS = scan_pkg::GUARD_TICKS
`endif
) (
   input  logic              clk,
   input  logic              rst,
   panel_scan_ctrl_if.master bus
);
   import scan_pkg::*;

   localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int PLANE_W = (DEPTH > 1)    ? $clog2(DEPTH)    : 1;
   localparam int TMR_W   = $clog2(BASE_TICKS) + DEPTH;

   localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NUM_COLS - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_ROWS - 1);
   localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(DEPTH - 1);

   scan_state_e        r_state, w_state_nxt;
   logic               r_phase, w_phase_nxt;
   logic [COL_W-1:0]   r_col,   w_col_nxt;
   logic [ROW_W-1:0]   r_row,   w_row_nxt;
   logic [PLANE_W-1:0] r_plane, w_plane_nxt;
   logic [ROW_W-1:0]   r_abc,   w_abc_nxt;
   logic               r_sclk,  w_sclk_nxt;
   logic               r_lat,   w_lat_nxt;
   logic               r_blank, w_blank_nxt;
   logic               r_frame_done, w_frame_done_nxt;
   logic               w_tmr_load;
   logic [TMR_W-1:0]   w_tmr_val;
   logic [TMR_W-1:0]   w_disp_val;
   logic               w_tmr_done;

   assign w_disp_val = TMR_W'(plane_ticks(BASE_TICKS, 32'(r_plane)) - 32'd1);

   scan_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_done     (w_tmr_done)
   );

   // Next-state, next-position and next-output decode; outputs are then registered.
   always_comb begin
      w_state_nxt      = r_state;
      w_phase_nxt      = r_phase;
      w_col_nxt        = r_col;
      w_row_nxt        = r_row;
      w_plane_nxt      = r_plane;
      w_abc_nxt        = r_abc;
      w_frame_done_nxt = 1'b0;
      w_tmr_load       = 1'b0;
      w_tmr_val        = '0;

      case (r_state)
         IDLE: begin
            if (bus.en) begin
               w_state_nxt = SHIFT;
               w_col_nxt   = '0;
               w_phase_nxt = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (!r_phase) begin
               w_phase_nxt = 1'b1;
            end else if (r_col == COL_LAST) begin
               w_phase_nxt = 1'b0;
               w_col_nxt   = '0;
               w_abc_nxt   = r_row;
               w_state_nxt = LATCH;
            end else begin
               w_phase_nxt = 1'b0;
               w_col_nxt   = r_col + COL_W'(1);
            end
         end
         LATCH: begin
            w_tmr_load  = 1'b1;
`ifdef SCAN_GHOST_GUARD_EN
            w_state_nxt = GUARD;
            w_tmr_val   = TMR_W'(GUARD_TICKS - 1);
`else
            w_state_nxt = DISPLAY;
            w_tmr_val   = w_disp_val;
`endif
         end
`ifdef SCAN_GHOST_GUARD_EN
         GUARD: begin
            if (w_tmr_done) begin
               w_state_nxt = DISPLAY;
               w_tmr_load  = 1'b1;
               w_tmr_val   = w_disp_val;
            end else begin
               w_state_nxt = GUARD;
            end
         end
`endif
         DISPLAY: begin
            if (w_tmr_done) begin
               w_col_nxt   = '0;
               w_phase_nxt = 1'b0;
               w_state_nxt = SHIFT;
               if (r_plane != PLANE_LAST) begin
                  w_plane_nxt = r_plane + PLANE_W'(1);
               end else begin
                  w_plane_nxt = '0;
                  if (r_row != ROW_LAST) begin
                     w_row_nxt = r_row + ROW_W'(1);
                  end else begin
                     // Frame boundary: the only place en is honoured after start.
                     w_row_nxt        = '0;
                     w_frame_done_nxt = 1'b1;
                     if (bus.en) begin
                        w_state_nxt = SHIFT;
                     end else begin
                        w_state_nxt = IDLE;
                     end
                  end
               end
            end else begin
               w_state_nxt = DISPLAY;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_sclk_nxt  = (w_state_nxt == SHIFT) && w_phase_nxt;
      w_lat_nxt   = (w_state_nxt == LATCH);
      w_blank_nxt = (w_state_nxt != DISPLAY);
   end

   // State, scan position and panel output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_phase      <= 1'b0;
         r_col        <= '0;
         r_row        <= '0;
         r_plane      <= '0;
         r_abc        <= '0;
         r_sclk       <= 1'b0;
         r_lat        <= 1'b0;
         r_blank      <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_phase      <= w_phase_nxt;
         r_col        <= w_col_nxt;
         r_row        <= w_row_nxt;
         r_plane      <= w_plane_nxt;
         r_abc        <= w_abc_nxt;
         r_sclk       <= w_sclk_nxt;
         r_lat        <= w_lat_nxt;
         r_blank      <= w_blank_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   assign bus.sclk       = r_sclk;
   assign bus.lat        = r_lat;
   assign bus.blank      = r_blank;
   assign bus.abc        = r_abc;
   assign bus.col        = r_col;
   assign bus.row        = r_row;
   assign bus.plane      = r_plane;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Directed bench for panel_scan_ctrl: reset, column shift, BCM plane timing, frame length, en drop, mid-display reset.
module tb_panel_scan_ctrl;

`ifdef SCAN_GHOST_GUARD_EN
   localparam int GT = 2;
`else
   localparam int GT = 0;
`endif
   localparam int FRAME = 4000 + 32 * GT;
   localparam logic [16:0] RST_OUTS = {1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0, 3'd0, 2'd0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_sclk = 1'b0;
   logic [2:0] prev_row = 3'd0;
   logic [1:0] prev_plane = 2'd0;

   panel_scan_ctrl_if bus ();

   panel_scan_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] outs();
      return {bus.sclk, bus.lat, bus.blank, bus.frame_done, bus.abc, bus.col, bus.row, bus.plane};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock, sampled 1 time unit after the edge, with the latch/blank invariants checked every cycle.
   task automatic step();
      prev_sclk  = bus.sclk;
      prev_row   = bus.row;
      prev_plane = bus.plane;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.lat === 1'b1) chk("lat_inv", 32'({bus.sclk, bus.blank}), 32'h1);
      if (bus.blank === 1'b0) chk("dark_inv", 32'({bus.sclk, bus.lat}), 32'h0);
   endtask

   // Shift one row/plane and measure its lit time; expects to start before the lat pulse.
   task automatic run_plane(input int p, input int exp_row);
      int nsclk = 0;
      int nlit = 0;
      for (int n = 0; n < 200 && bus.lat !== 1'b1; n++) begin
         step();
         if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
            chk("col_at_sclk", 32'(bus.col), nsclk);
            nsclk++;
         end
      end
      chk("lat_seen", 32'(bus.lat), 32'h1);
      chk("sclk_count", nsclk, 32);
      chk("abc_eq_row", 32'(bus.abc), exp_row);
      chk("row_at_lat", 32'(bus.row), exp_row);
      chk("plane_at_lat", 32'(bus.plane), p);
      step();
      chk("lat_one_cycle", 32'(bus.lat), 32'h0);
      for (int n = 0; n < 10 && bus.blank !== 1'b0; n++) step();
      for (int n = 0; n < 300 && bus.blank === 1'b0; n++) begin
         nlit++;
         step();
      end
      chk("lit_cycles", nlit, 16 << p);
   endtask

   initial begin
      int fstart;
      bus.en = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_outs", 32'(outs()), 32'(RST_OUTS));
      end
      rst = 1'b0;
      step();
      fstart = cyc;
      chk("first_shift", 32'({bus.sclk, bus.blank, bus.col}), 32'({1'b0, 1'b1, 5'd0}));

      for (int p = 0; p < 4; p++) run_plane(p, 0);
      chk("row_after_planes", 32'({bus.row, bus.plane}), 32'({3'd1, 2'd0}));

      for (int n = 0; n < 5000 && bus.frame_done !== 1'b1; n++) step();
      chk("frame_done_seen", 32'(bus.frame_done), 32'h1);
      chk("frame_len", cyc - fstart, FRAME);
      chk("wrap_prev", 32'({prev_row, prev_plane}), 32'({3'd7, 2'd3}));
      chk("wrap_now", 32'({bus.row, bus.plane}), 32'({3'd0, 2'd0}));
      fstart = cyc;
      step();
      chk("frame_done_pulse", 32'(bus.frame_done), 32'h0);

      // Drop en 1000 cycles into the second frame; the frame must still complete.
      while (cyc - fstart < 1000) step();
      bus.en = 1'b0;
      for (int n = 0; n < 5000 && bus.frame_done !== 1'b1; n++) step();
      chk("frame2_done_seen", 32'(bus.frame_done), 32'h1);
      chk("frame2_len", cyc - fstart, FRAME);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_quiet", 32'({bus.sclk, bus.lat, bus.blank}), 32'({1'b0, 1'b0, 1'b1}));
      end

      bus.en = 1'b1;
      step();
      chk("restart_shift", 32'({bus.sclk, bus.blank, bus.col, bus.row, bus.plane}), 32'({1'b0, 1'b1, 5'd0, 3'd0, 2'd0}));
      for (int n = 0; n < 5000 && !(bus.row === 3'd5 && bus.plane === 2'd2 && bus.blank === 1'b0); n++) step();
      chk("reach_r5p2", 32'({bus.row, bus.plane, bus.blank}), 32'({3'd5, 2'd2, 1'b0}));
      step();
      step();
      rst = 1'b1;
      step();
      chk("mid_reset_outs", 32'(outs()), 32'(RST_OUTS));
      rst = 1'b0;
      step();
      chk("post_reset_shift", 32'({bus.sclk, bus.blank, bus.col, bus.row, bus.plane}), 32'({1'b0, 1'b1, 5'd0, 3'd0, 2'd0}));
      run_plane(0, 0);
      chk("post_reset_plane1", 32'({bus.row, bus.plane}), 32'({3'd0, 2'd1}));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
